fsm_stage_sequencer: RTL and testbench

Parametrised one-hot stage sequencer, the generalised successor to the fixed three-state READY/SET/GO decoders. It walks NUM_STATES stages in order, holds each stage for a programmable number of cycles, and supports a start/hold/abort control set. It runs in one-shot or wrap-around mode. Illegal state encodings are detected and recovered deterministically instead of being left to a default branch. It sits between a controller issuing `start` and downstream logic that consumes the one-hot stage strobes.

---
 rtl/fsm_seq_pkg.sv | 19 +
 rtl/fsm_seq_dwell_counter.sv | 24 ++
 rtl/fsm_stage_sequencer.sv | 116 +++++++++++
 tb/tb_fsm_stage_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared constants and one-hot helpers for the stage sequencer
package fsm_seq_pkg;
  localparam int MAX_STATES = 16;
  localparam int MIN_STATES = 2;
  localparam int MAX_IDX_W  = 4;

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_STATES-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_STATES; i++) begin
      if (v[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot0(input logic [MAX_STATES-1:0] v);
    return (v & (v - MAX_STATES'(1))) == '0;
  endfunction
endpackage

// File: rtl/fsm_seq_dwell_counter.sv
// rtl/fsm_seq_dwell_counter.sv - per-stage dwell counter: load, decrement, otherwise hold
module fsm_seq_dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic [DWELL_W-1:0] cnt,
  output logic               zero
);
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/fsm_stage_sequencer.sv
// rtl/fsm_stage_sequencer.sv - one-hot stage sequencer with per-stage dwell, hold/abort,
// optional wrap, and recovery from multi-hot state encodings.
module fsm_stage_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int NUM_STATES = 3,
  parameter int DWELL_W    = 4,
  parameter int WRAP       = 0,
  parameter int IDX_W      = $clog2(NUM_STATES)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          start,
  input  logic                          hold,
  input  logic                          abort,
  input  logic [NUM_STATES*DWELL_W-1:0] dwell,
  output logic [NUM_STATES-1:0]         stage_onehot,
  output logic [IDX_W-1:0]              stage_idx,
  output logic                          busy,
  output logic                          stage_enter,
  output logic                          done,
  output logic                          illegal
);
  if (NUM_STATES < MIN_STATES || NUM_STATES > MAX_STATES) begin : g_bad_num_states
    $error("fsm_stage_sequencer: NUM_STATES out of range");
  end

  logic [NUM_STATES-1:0] st, st_nxt;
  logic [DWELL_W-1:0]    dwell_arr [NUM_STATES];
  logic [DWELL_W-1:0]    cnt, load_val;
  logic                  cnt_zero, load, dec;
  logic                  legal;
  logic [NUM_STATES-1:0] st_vis;
  logic [MAX_IDX_W-1:0]  idx_full;
  logic                  unused_idx_bits;
  logic [IDX_W-1:0]      next_idx;
  logic                  enter_nxt, done_nxt, illegal_nxt;

  for (genvar i = 0; i < NUM_STATES; i++) begin : g_dwell
    assign dwell_arr[i] = dwell[i*DWELL_W +: DWELL_W];
  end

  // Multi-hot encodings are masked so downstream never sees two strobes at once.
  assign legal           = is_onehot0(MAX_STATES'(st));
  assign st_vis          = legal ? st : '0;
  assign idx_full        = onehot_to_idx(MAX_STATES'(st_vis));
  assign unused_idx_bits = ^idx_full;
  assign stage_idx       = idx_full[IDX_W-1:0];
  assign stage_onehot    = st_vis;
  assign busy            = |st_vis;
  assign next_idx        = stage_idx + IDX_W'(1);

  fsm_seq_dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
    .clock    (clock),
    .resetN   (resetN),
    .load     (load),
    .dec      (dec),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    st_nxt      = st;
    load        = 1'b0;
    dec         = 1'b0;
    load_val    = dwell_arr[0];
    enter_nxt   = 1'b0;
    done_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    if (abort) begin
      st_nxt = '0;
    end else if (!legal) begin
      st_nxt      = '0;
      illegal_nxt = 1'b1;
    end else if (hold) begin
      st_nxt = st;
    end else if (st == '0) begin
      if (start) begin
        st_nxt    = NUM_STATES'(1);
        load      = 1'b1;
        enter_nxt = 1'b1;
      end
    end else if (!cnt_zero) begin
      dec = 1'b1;
    end else if (st[NUM_STATES-1]) begin
      done_nxt = 1'b1;
      if (WRAP != 0) begin
        st_nxt    = NUM_STATES'(1);
        load      = 1'b1;
        enter_nxt = 1'b1;
      end else begin
        st_nxt = '0;
      end
    end else begin
      st_nxt    = {st[NUM_STATES-2:0], 1'b0};
      load      = 1'b1;
      load_val  = dwell_arr[next_idx];
      enter_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      st          <= '0;
      stage_enter <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      st          <= st_nxt;
      stage_enter <= enter_nxt;
      done        <= done_nxt;
      illegal     <= illegal_nxt;
    end
  end
endmodule

// File: tb/tb_fsm_stage_sequencer.sv
// tb/tb_fsm_stage_sequencer.sv - directed, table-driven bench for fsm_stage_sequencer
module tb_fsm_stage_sequencer;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clock, resetN;
  logic        start, hold, abort;
  logic [11:0] dwell;
  logic [2:0]  stage_onehot;
  logic [1:0]  stage_idx;
  logic        busy, stage_enter, done, illegal;

  logic        w_start, w_hold, w_abort;
  logic [11:0] w_dwell;
  logic [2:0]  w_onehot;
  logic [1:0]  w_idx;
  logic        w_busy, w_enter, w_done, w_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_stage_sequencer #(.NUM_STATES(3), .DWELL_W(4), .WRAP(0)) dut (
    .clock(clock), .resetN(resetN), .start(start), .hold(hold), .abort(abort),
    .dwell(dwell), .stage_onehot(stage_onehot), .stage_idx(stage_idx), .busy(busy),
    .stage_enter(stage_enter), .done(done), .illegal(illegal)
  );

  fsm_stage_sequencer #(.NUM_STATES(3), .DWELL_W(4), .WRAP(1)) dut_w (
    .clock(clock), .resetN(resetN), .start(w_start), .hold(w_hold), .abort(w_abort),
    .dwell(w_dwell), .stage_onehot(w_onehot), .stage_idx(w_idx), .busy(w_busy),
    .stage_enter(w_enter), .done(w_done), .illegal(w_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       s, h, a;
    logic [2:0] oh;
    logic [1:0] idx;
    logic       en, dn, bz;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic a);
    @(negedge clock);
    start = s; hold = h; abort = a;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] oh, input logic [1:0] idx,
                            input logic en, input logic dn, input logic bz, input logic il);
    check({tag, " onehot"},  32'(stage_onehot), 32'(oh));
    check({tag, " idx"},     32'(stage_idx),    32'(idx));
    check({tag, " enter"},   32'(stage_enter),  32'(en));
    check({tag, " done"},    32'(done),         32'(dn));
    check({tag, " busy"},    32'(busy),         32'(bz));
    check({tag, " illegal"}, 32'(illegal),      32'(il));
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      step(tbl[i].s, tbl[i].h, tbl[i].a);
      check_outs($sformatf("row%0d", i), tbl[i].oh, tbl[i].idx, tbl[i].en, tbl[i].dn, tbl[i].bz, L);
    end
    start = L; hold = L; abort = L;
  endtask

  logic [2:0] w_exp_oh [8];
  logic       w_exp_dn [8];
  logic       w_exp_en [8];

  initial begin
    // one-shot, stage0=0 stage1=1 stage2=2
    tbl[0]  = '{H,L,L,3'b001,2'd0,H,L,H};
    tbl[1]  = '{L,L,L,3'b010,2'd1,H,L,H};
    tbl[2]  = '{L,L,L,3'b010,2'd1,L,L,H};
    tbl[3]  = '{L,L,L,3'b100,2'd2,H,L,H};
    tbl[4]  = '{L,L,L,3'b100,2'd2,L,L,H};
    tbl[5]  = '{L,L,L,3'b100,2'd2,L,L,H};
    tbl[6]  = '{L,L,L,3'b000,2'd0,L,H,L};
    tbl[7]  = '{L,L,L,3'b000,2'd0,L,L,L};
    // two held cycles in stage 1, plus a mid-sequence start that must be ignored
    tbl[8]  = '{H,L,L,3'b001,2'd0,H,L,H};
    tbl[9]  = '{L,L,L,3'b010,2'd1,H,L,H};
    tbl[10] = '{L,H,L,3'b010,2'd1,L,L,H};
    tbl[11] = '{L,H,L,3'b010,2'd1,L,L,H};
    tbl[12] = '{H,L,L,3'b010,2'd1,L,L,H};
    tbl[13] = '{L,L,L,3'b100,2'd2,H,L,H};
    tbl[14] = '{L,L,L,3'b100,2'd2,L,L,H};
    tbl[15] = '{L,L,L,3'b100,2'd2,L,L,H};
    tbl[16] = '{L,L,L,3'b000,2'd0,L,H,L};
    tbl[17] = '{L,L,L,3'b000,2'd0,L,L,L};
    // abort in stage 1, abort+start while idle, hold while idle
    tbl[18] = '{H,L,L,3'b001,2'd0,H,L,H};
    tbl[19] = '{L,L,L,3'b010,2'd1,H,L,H};
    tbl[20] = '{L,L,H,3'b000,2'd0,L,L,L};
    tbl[21] = '{L,L,L,3'b000,2'd0,L,L,L};
    tbl[22] = '{H,L,H,3'b000,2'd0,L,L,L};
    tbl[23] = '{L,L,L,3'b000,2'd0,L,L,L};
    tbl[24] = '{H,H,L,3'b000,2'd0,L,L,L};
    tbl[25] = '{L,L,L,3'b000,2'd0,L,L,L};

    w_exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    w_exp_dn = '{L, L, L, H, L, L, H, L};
    w_exp_en = '{H, H, H, H, H, H, H, L};

    resetN = 1'b0;
    start = L; hold = L; abort = L;
    w_start = L; w_hold = L; w_abort = L;
    dwell   = {4'd2, 4'd1, 4'd0};
    w_dwell = {4'd0, 4'd0, 4'd0};
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 3'b000, 2'd0, L, L, L, L);
    @(negedge clock);
    resetN = 1'b1;

    // reset mid-sequence takes effect without waiting for a clock edge
    step(H, L, L);
    step(L, L, L);
    check("pre-reset onehot", 32'(stage_onehot), 32'(3'b010));
    @(negedge clock);
    #2 resetN = 1'b0;
    #1 check_outs("async reset", 3'b000, 2'd0, L, L, L, L);
    @(negedge clock);
    resetN = 1'b1;
    start = L;
    @(posedge clock);
    #1 check_outs("post-reset idle", 3'b000, 2'd0, L, L, L, L);

    run_rows(0, 25);

    // multi-hot state: recovered to idle with an illegal pulse; abort flushes any residue
    @(negedge clock);
    force dut.st = 3'b011;
    @(posedge clock);
    #1 check_outs("illegal detect", 3'b000, 2'd0, L, L, L, H);
    @(negedge clock);
    release dut.st;
    abort = H;
    @(posedge clock);
    #1 check_outs("illegal cleared", 3'b000, 2'd0, L, L, L, L);
    abort = L;
    run_rows(0, 7);

    // wrap mode loops until aborted
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      w_start = (i == 0) ? H : L;
      w_abort = (i == 7) ? H : L;
      @(posedge clock);
      #1;
      check($sformatf("wrap%0d onehot", i), 32'(w_onehot), 32'(w_exp_oh[i]));
      check($sformatf("wrap%0d done", i),   32'(w_done),   32'(w_exp_dn[i]));
      check($sformatf("wrap%0d enter", i),  32'(w_enter),  32'(w_exp_en[i]));
    end
    @(negedge clock);
    w_abort = L;
    @(posedge clock);
    #1;
    check("wrap stopped busy", 32'(w_busy), 32'(L));
    check("wrap stopped done", 32'(w_done), 32'(L));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
